// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares one single-port instruction RAM between the fetch stage (read-only)
// and the loader/debug port (read/write). At most one access is granted per
// cycle. Read data comes back one cycle after the grant and is routed to the
// requester that issued the read. Addresses outside the RAM are still
// granted: writes are dropped, and reads return a substitute word.
module imem_port_arbiter #(
    parameter int          ADDR_W    = 10,
    parameter int          MAX_BURST = 4,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [31:0]       f_rdata,
    output logic              f_stall,
    // loader / debug port
    input  logic              l_req,
    input  logic              l_we,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_valid,
    output logic [31:0]       l_rdata,
    // RAM port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int             CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_FETCH,
        RSP_LOAD
    } rsp_state_t;

    rsp_state_t       state_q, state_d;
    logic             oor_q, oor_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic f_oor;
    logic l_oor;
    logic burst_full;
    logic unused_addr_lsbs;

    // Byte-offset bits are don't-care for word-addressed RAM.
    assign unused_addr_lsbs = ^{f_addr[1:0], l_addr[1:0]};

    assign f_oor      = |f_addr[31:ADDR_W+2];
    assign l_oor      = |l_addr[31:ADDR_W+2];
    assign burst_full = (burst_cnt_q == BURST_MAX);

    // Grant: the loader normally wins. Fetch wins once the loader has had
    // MAX_BURST consecutive grants while fetch was waiting.
    always_comb begin
        f_gnt   = 1'b0;
        l_gnt   = 1'b0;
        f_stall = 1'b0;
        if (!rst) begin
            if (f_req && (!l_req || burst_full)) begin
                f_gnt = 1'b1;
            end else if (l_req) begin
                l_gnt = 1'b1;
            end
            f_stall = f_req && !f_gnt;
        end
    end

    // Burst counter: counts loader grants taken while fetch waits. It clears
    // whenever fetch is served or stops asking.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (rst || !f_req || f_gnt) begin
            burst_cnt_d = '0;
        end else if (l_gnt && !burst_full) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    // RAM port: combinational copy of the granted request. Out-of-range
    // accesses keep the RAM disabled.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (f_gnt) begin
            mem_en   = !f_oor;
            mem_addr = f_addr[ADDR_W+1:2];
        end else if (l_gnt) begin
            mem_en    = !l_oor;
            mem_we    = l_we && !l_oor;
            mem_addr  = l_addr[ADDR_W+1:2];
            mem_wdata = l_wdata;
        end
    end

    // Response FSM next state: records who owns next cycle's read data and
    // whether that read was out of range.
    always_comb begin
        state_d = RSP_IDLE;
        oor_d   = 1'b0;
        if (f_gnt) begin
            state_d = RSP_FETCH;
            oor_d   = f_oor;
        end else if (l_gnt && !l_we) begin
            state_d = RSP_LOAD;
            oor_d   = l_oor;
        end
    end

    // Response outputs: route RAM data (or the substitute word) to the owner.
    // Valid is suppressed while in reset so that an in-flight read is dropped.
    always_comb begin
        f_valid = 1'b0;
        f_rdata = '0;
        l_valid = 1'b0;
        l_rdata = '0;
        if (!rst) begin
            case (state_q)
                RSP_FETCH: begin
                    f_valid = 1'b1;
                    f_rdata = oor_q ? NOP_INSTR : mem_rdata;
                end
                RSP_LOAD: begin
                    l_valid = 1'b1;
                    l_rdata = oor_q ? 32'h0 : mem_rdata;
                end
                default: begin
                    f_valid = 1'b0;
                    l_valid = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RSP_IDLE;
            oor_q       <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            oor_q       <= oor_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter. A write-first RAM model sits on the
// memory port; a golden copy of the RAM contents is updated only from the
// intended stimulus, and expected responses go through a scoreboard queue.
module tb_imem_port_arbiter;

    localparam int          AW  = 10;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk;
    logic          rst;
    logic          f_req;
    logic [31:0]   f_addr;
    logic          f_gnt;
    logic          f_valid;
    logic [31:0]   f_rdata;
    logic          f_stall;
    logic          l_req;
    logic          l_we;
    logic [31:0]   l_addr;
    logic [31:0]   l_wdata;
    logic          l_gnt;
    logic          l_valid;
    logic [31:0]   l_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0] ram     [1 << AW];
    logic [31:0] exp_mem [1 << AW];

    typedef struct packed {
        logic [1:0]  kind;   // 0 none, 1 fetch, 2 loader
        logic [31:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    imem_port_arbiter #(
        .ADDR_W   (AW),
        .MAX_BURST(4),
        .NOP_INSTR(NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_valid  (f_valid),
        .f_rdata  (f_rdata),
        .f_stall  (f_stall),
        .l_req    (l_req),
        .l_we     (l_we),
        .l_addr   (l_addr),
        .l_wdata  (l_wdata),
        .l_gnt    (l_gnt),
        .l_valid  (l_valid),
        .l_rdata  (l_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first single-port RAM, one cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check last cycle's
    // response and this cycle's grant / RAM port, then queue the expected
    // response for the next cycle.
    task automatic step(input string tag, input logic r,
                        input logic fq, input logic [31:0] fa,
                        input logic lq, input logic lw, input logic [31:0] la,
                        input logic [31:0] ld, input logic efg, input logic elg);
        rsp_t        prev;
        rsp_t        cur;
        logic [31:0] ga;
        logic        ge;
        logic        goor;
        logic        ewe;
        rst     = r;
        f_req   = fq;
        f_addr  = fa;
        l_req   = lq;
        l_we    = lw;
        l_addr  = la;
        l_wdata = ld;
        #1;
        prev = '0;
        if (sb.size() > 0) prev = sb.pop_front();
        if (r) prev = '0;
        chk({tag, ".f_valid"}, 32'(f_valid), 32'(prev.kind == 2'd1));
        chk({tag, ".f_rdata"}, f_rdata, (prev.kind == 2'd1) ? prev.data : 32'h0);
        chk({tag, ".l_valid"}, 32'(l_valid), 32'(prev.kind == 2'd2));
        chk({tag, ".l_rdata"}, l_rdata, (prev.kind == 2'd2) ? prev.data : 32'h0);
        chk({tag, ".f_gnt"}, 32'(f_gnt), 32'(efg));
        chk({tag, ".l_gnt"}, 32'(l_gnt), 32'(elg));
        ge   = efg | elg;
        ga   = efg ? fa : la;
        goor = |ga[31:AW+2];
        ewe  = elg & lw & ~goor;
        chk({tag, ".mem_en"}, 32'(mem_en), 32'(ge & ~goor));
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(ewe));
        if (ge && !goor) chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(ga[AW+1:2]));
        if (ewe) chk({tag, ".mem_wdata"}, mem_wdata, ld);
        if (r) begin
            chk({tag, ".rst_mem_addr"}, 32'(mem_addr), 32'h0);
            chk({tag, ".rst_mem_wdata"}, mem_wdata, 32'h0);
            chk({tag, ".rst_f_stall"}, 32'(f_stall), 32'h0);
        end else begin
            chk({tag, ".f_stall"}, 32'(f_stall), 32'(fq & ~efg));
        end
        cur = '0;
        if (efg) begin
            cur.kind = 2'd1;
            cur.data = goor ? NOP : exp_mem[ga[AW+1:2]];
        end else if (elg && !lw) begin
            cur.kind = 2'd2;
            cur.data = goor ? 32'h0 : exp_mem[ga[AW+1:2]];
        end else if (ewe) begin
            exp_mem[ga[AW+1:2]] = ld;
        end
        sb.push_back(cur);
        $display("step %s: f_gnt=%0b l_gnt=%0b f_valid=%0b f_rdata=%h l_valid=%0b l_rdata=%h",
                 tag, f_gnt, l_gnt, f_valid, f_rdata, l_valid, l_rdata);
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        f_req     = 1'b0;
        f_addr    = '0;
        l_req     = 1'b0;
        l_we      = 1'b0;
        l_addr    = '0;
        l_wdata   = '0;
        mem_rdata = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = 32'hA5000000 ^ (i * 32'h00010203);
            exp_mem[i] = 32'hA5000000 ^ (i * 32'h00010203);
        end
        @(negedge clk);

        // Reset with requests active: no grants, all outputs quiet.
        step("rst0", 1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
        step("rst1", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Lone fetch read.
        step("t1_fetch", 1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle("t1_resp");

        // Loader write then fetch of the same word (consecutive cycles).
        step("t2_lwr", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
        step("t2_fetch", 1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step("t2_lrd", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
        idle("t2_resp");

        // Back-to-back fetch reads.
        for (int i = 0; i < 3; i++)
            step($sformatf("b2b%0d", i), 1'b0, 1'b1, 32'h40 + 32'(4 * i),
                 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Contention: loader bursts of 4, then fetch gets a turn.
        for (int i = 0; i < 10; i++)
            step($sformatf("t3_%0d", i), 1'b0, 1'b1, 32'h100 + 32'(4 * i),
                 1'b1, 1'b0, 32'h200 + 32'(4 * i), 32'h0,
                 (i == 4 || i == 9), !(i == 4 || i == 9));
        idle("t3_resp");

        // A cycle with f_req low clears the burst count.
        step("clr0", 1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1);
        step("clr1", 1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h28, 32'h0, 1'b0, 1'b1);
        step("clr2", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h2C, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            step($sformatf("clr_c%0d", i), 1'b0, 1'b1, 32'h30, 1'b1, 1'b0,
                 32'h34 + 32'(4 * i), 32'h0, (i == 4), (i != 4));
        idle("clr_resp");

        // Out-of-range accesses.
        step("t4_foor", 1'b0, 1'b1, 32'h00001000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step("t4_lwoor", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00001000, 32'h12345678, 1'b0, 1'b1);
        step("t4_lroor", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h80000000, 32'h0, 1'b0, 1'b1);
        step("t4_fchk", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step("t4_fhigh", 1'b0, 1'b1, 32'h80000004, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle("t4_resp");

        // Reset mid-read discards the response and clears the burst count.
        step("t5_lb0", 1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 1'b1);
        step("t5_lb1", 1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 32'h54, 32'h0, 1'b0, 1'b1);
        step("t5_fetch", 1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step("t5_rst", 1'b1, 1'b1, 32'hC, 1'b1, 1'b0, 32'h58, 32'h0, 1'b0, 1'b0);
        step("t5_post", 1'b0, 1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step("t5_lb2", 1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 1'b1);
        step("t5_lb3", 1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 32'h64, 32'h0, 1'b0, 1'b1);
        step("t5_rst2", 1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h68, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step($sformatf("t5_c%0d", i), 1'b0, 1'b1, 32'h70, 1'b1, 1'b0,
                 32'h74 + 32'(4 * i), 32'h0, (i == 4), (i != 4));
        idle("t5_resp");
        idle("end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
